// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch-PC generator: branch opcode encodings,
// reset / exception addresses and the fetch FSM state type.
package cpu_defs_pkg;

   localparam logic [2:0] BR_BEQ  = 3'd0;
   localparam logic [2:0] BR_BNE  = 3'd1;
   localparam logic [2:0] BR_BLEZ = 3'd2;
   localparam logic [2:0] BR_BGTZ = 3'd3;
   localparam logic [2:0] BR_BLTZ = 3'd4;
   localparam logic [2:0] BR_BGEZ = 3'd5;
   localparam logic [2:0] BR_J    = 3'd6;
   localparam logic [2:0] BR_JR   = 3'd7;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_gen_br_resolve.sv
// Combinational branch resolver: decides whether the D-stage control
// transfer is taken and computes its target and the JR misalignment flag.
module br_resolve #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned IMM_WIDTH   = 16,
   parameter int unsigned INDEX_WIDTH = 26
) (
   input  logic                   valid,
   input  logic [2:0]             op,
   input  logic [WIDTH-1:0]       pc,
   input  logic [WIDTH-1:0]       rs,
   input  logic [WIDTH-1:0]       rt,
   input  logic [IMM_WIDTH-1:0]   imm,
   input  logic [INDEX_WIDTH-1:0] index,
   output logic                   taken,
   output logic [WIDTH-1:0]       target,
   output logic                   misalign
);
   import cpu_defs_pkg::*;

   logic signed [WIDTH-1:0] rs_s;
   logic signed [WIDTH-1:0] off_s;
   logic [WIDTH-1:0]        pc4;
   logic [WIDTH-1:0]        br_tgt;
   logic [WIDTH-1:0]        j_tgt;
   logic [WIDTH-1:0]        jr_tgt;
   logic                    rs_neg;
   logic                    rs_zero;

   // Operand views and the three candidate targets
   always_comb begin
      rs_s    = rs;
      off_s   = {{(WIDTH-IMM_WIDTH-2){imm[IMM_WIDTH-1]}}, imm, 2'b00};
      pc4     = pc + WIDTH'(4);
      br_tgt  = pc4 + off_s;
      j_tgt   = {pc4[WIDTH-1:INDEX_WIDTH+2], index, 2'b00};
      jr_tgt  = {rs[WIDTH-1:2], 2'b00};
      rs_neg  = (rs_s < 0);
      rs_zero = (rs == '0);
   end

   // Taken decision and target select; nothing is taken without valid
   always_comb begin
      taken  = 1'b0;
      target = br_tgt;
      case (op)
         BR_BEQ:  taken = (rs == rt);
         BR_BNE:  taken = (rs != rt);
         BR_BLEZ: taken = rs_neg | rs_zero;
         BR_BGTZ: taken = ~rs_neg & ~rs_zero;
         BR_BLTZ: taken = rs_neg;
         BR_BGEZ: taken = ~rs_neg;
         BR_J: begin
            taken  = 1'b1;
            target = j_tgt;
         end
         BR_JR: begin
            taken  = 1'b1;
            target = jr_tgt;
         end
         default: taken = 1'b0;
      endcase
      taken    = taken & valid;
      misalign = valid & (op == BR_JR) & (rs[1:0] != 2'b00);
   end

endmodule

// File: rtl/pc_gen.sv
// Registered fetch-PC generator. Owns the PC, resolves D-stage branches,
// honours stall / IM-ready and buffers a redirect that cannot be applied.
// Optional macro PC_GEN_EXC_EN adds exception entry (exc_i) and return
// (eret_i / epc_i) with priority over everything else.
module pc_gen #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(cpu_defs_pkg::RESET_PC),
   parameter int unsigned      IMM_WIDTH   = 16,
   parameter int unsigned      INDEX_WIDTH = 26
`ifdef PC_GEN_EXC_EN
   ,parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(cpu_defs_pkg::EXC_VECTOR)
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall_i,
   input  logic                   fetch_ready_i,
   input  logic                   br_valid_i,
   input  logic [2:0]             br_op_i,
   input  logic [WIDTH-1:0]       br_pc_i,
   input  logic [WIDTH-1:0]       rs_val_i,
   input  logic [WIDTH-1:0]       rt_val_i,
   input  logic [IMM_WIDTH-1:0]   imm_i,
   input  logic [INDEX_WIDTH-1:0] index_i,
`ifdef PC_GEN_EXC_EN
   input  logic                   exc_i,
   input  logic                   eret_i,
   input  logic [WIDTH-1:0]       epc_i,
`endif
   output logic [WIDTH-1:0]       pc_o,
   output logic                   fetch_valid_o,
   output logic                   redirect_o,
   output logic                   misalign_o
);
   import cpu_defs_pkg::*;

   pc_state_e        state;
   logic [WIDTH-1:0] pending;
   logic             taken;
   logic             misalign;
   logic [WIDTH-1:0] target;
   logic             adv;
   logic             consider;

   br_resolve #(
      .WIDTH       (WIDTH),
      .IMM_WIDTH   (IMM_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_br_resolve (
      .valid    (br_valid_i),
      .op       (br_op_i),
      .pc       (br_pc_i),
      .rs       (rs_val_i),
      .rt       (rt_val_i),
      .imm      (imm_i),
      .index    (index_i),
      .taken    (taken),
      .target   (target),
      .misalign (misalign)
   );

   // Fetch advance, and whether D-stage branch inputs count this cycle
   // (in HOLD an advancing cycle applies pending; D re-presents its branch)
   always_comb begin
      adv      = fetch_valid_o & fetch_ready_i & ~stall_i;
      consider = (state == RUN) | ((state == HOLD) & ~adv);
   end

   // PC register, redirect buffer and fetch FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_o          <= RESET_PC;
         fetch_valid_o <= 1'b0;
         redirect_o    <= 1'b0;
         misalign_o    <= 1'b0;
         pending       <= '0;
         state         <= BOOT;
      end else begin
         redirect_o <= consider & taken;
         misalign_o <= consider & misalign;
         case (state)
            BOOT: begin
               state         <= RUN;
               fetch_valid_o <= 1'b1;
            end
            RUN: begin
               if (adv) begin
                  pc_o <= taken ? target : pc_o + WIDTH'(4);
               end else if (taken) begin
                  pending <= target;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (adv) begin
                  pc_o  <= pending;
                  state <= RUN;
               end else if (taken) begin
                  pending <= target;
               end
            end
            default: state <= BOOT;
         endcase
`ifdef PC_GEN_EXC_EN
         if (exc_i) begin
            pc_o          <= EXC_VECTOR;
            pending       <= '0;
            state         <= RUN;
            fetch_valid_o <= 1'b1;
            redirect_o    <= 1'b0;
            misalign_o    <= 1'b0;
         end else if (eret_i) begin
            pc_o          <= epc_i;
            pending       <= '0;
            state         <= RUN;
            fetch_valid_o <= 1'b1;
            redirect_o    <= 1'b0;
            misalign_o    <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-cycle stimulus with expected outputs
// queued alongside it and compared one cycle after each edge.
module tb_pc_gen;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        fetch_ready_i;
   logic        br_valid_i;
   logic [2:0]  br_op_i;
   logic [31:0] br_pc_i;
   logic [31:0] rs_val_i;
   logic [31:0] rt_val_i;
   logic [15:0] imm_i;
   logic [25:0] index_i;
`ifdef PC_GEN_EXC_EN
   logic        exc_i;
   logic        eret_i;
   logic [31:0] epc_i;
`endif
   logic [31:0] pc_o;
   logic        fetch_valid_o;
   logic        redirect_o;
   logic        misalign_o;

   typedef struct {
      logic        stall;
      logic        ready;
      logic        bv;
      logic [2:0]  op;
      logic [31:0] bpc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [25:0] idx;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        rd;
      logic        ms;
   } exp_t;

   stim_t stq[$];
   exp_t  sbq[$];
   int    total = 0;
   int    bad   = 0;

   pc_gen dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .fetch_ready_i (fetch_ready_i),
      .br_valid_i    (br_valid_i),
      .br_op_i       (br_op_i),
      .br_pc_i       (br_pc_i),
      .rs_val_i      (rs_val_i),
      .rt_val_i      (rt_val_i),
      .imm_i         (imm_i),
      .index_i       (index_i),
`ifdef PC_GEN_EXC_EN
      .exc_i         (exc_i),
      .eret_i        (eret_i),
      .epc_i         (epc_i),
`endif
      .pc_o          (pc_o),
      .fetch_valid_o (fetch_valid_o),
      .redirect_o    (redirect_o),
      .misalign_o    (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply(input stim_t s);
      stall_i       = s.stall;
      fetch_ready_i = s.ready;
      br_valid_i    = s.bv;
      br_op_i       = s.op;
      br_pc_i       = s.bpc;
      rs_val_i      = s.rs;
      rt_val_i      = s.rt;
      imm_i         = s.imm;
      index_i       = s.idx;
`ifdef PC_GEN_EXC_EN
      exc_i         = s.exc;
      eret_i        = s.eret;
      epc_i         = s.epc;
`endif
   endtask

   // queue one cycle of stimulus together with the outputs expected after its edge
   task automatic add(input logic st, input logic rdy, input logic bv, input logic [2:0] op,
                      input logic [31:0] bpc, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] epc_val, input logic exc, input logic eret,
                      input logic [31:0] xpc, input logic xrd, input logic xms);
      stim_t s;
      exp_t  e;
      s.stall = st;  s.ready = rdy; s.bv = bv;   s.op = op;
      s.bpc = bpc;   s.rs = rs;     s.rt = rt;   s.imm = imm; s.idx = idx;
      s.exc = exc;   s.eret = eret; s.epc = epc_val;
      e.pc = xpc;    e.fv = 1'b1;   e.rd = xrd;  e.ms = xms;
      stq.push_back(s);
      sbq.push_back(e);
   endtask

   task automatic idle(input logic [31:0] xpc);
      add(0, 1, 0, 3'd0, 0, 0, 0, 16'h0, 26'h0, 0, 0, 0, xpc, 0, 0);
   endtask

   task automatic test_reset;
      stim_t s;
      exp_t  e;
      int    n = 0;
      s = '{default: '0};
      s.ready = 1'b1;
      apply(s);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {32'h0000_3000, 3'b000}) begin
         bad++;
         $display("FAIL reset_state: got pc=%h fv=%b rd=%b ms=%b want pc=00003000 fv=0 rd=0 ms=0",
                  pc_o, fetch_valid_o, redirect_o, misalign_o);
      end
      reset = 1'b0;
      idle(32'h3000);
      idle(32'h3004);
      idle(32'h3008);
      add(0, 0, 0, 3'd0, 0, 0, 0, 16'h0, 26'h0, 0, 0, 0, 32'h3008, 0, 0);
      idle(32'h300C);
      while (stq.size() > 0) begin
         s = stq.pop_front();
         apply(s);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {e.pc, e.fv, e.rd, e.ms}) begin
            bad++;
            $display("FAIL boot_seq step %0d: got pc=%h fv=%b rd=%b ms=%b want pc=%h fv=%b rd=%b ms=%b",
                     n, pc_o, fetch_valid_o, redirect_o, misalign_o, e.pc, e.fv, e.rd, e.ms);
         end
         n++;
      end
   endtask

   task automatic test_branches;
      stim_t s;
      exp_t  e;
      int    n = 0;
      add(0, 1, 1, 3'd0, 32'h3010, 5, 5, 16'hFFFC, 0, 0, 0, 0, 32'h3004, 1, 0);
      add(0, 1, 1, 3'd0, 32'h3010, 5, 6, 16'hFFFC, 0, 0, 0, 0, 32'h3008, 0, 0);
      add(0, 1, 1, 3'd1, 32'h3010, 5, 6, 16'hFFFC, 0, 0, 0, 0, 32'h3004, 1, 0);
      add(0, 1, 1, 3'd3, 32'h3010, 32'h8000_0000, 0, 16'h0004, 0, 0, 0, 0, 32'h3008, 0, 0);
      add(0, 1, 1, 3'd4, 32'h3010, 32'h8000_0000, 0, 16'h0004, 0, 0, 0, 0, 32'h3024, 1, 0);
      add(0, 1, 1, 3'd2, 32'h3010, 0, 0, 16'h0008, 0, 0, 0, 0, 32'h3034, 1, 0);
      add(0, 1, 1, 3'd5, 32'h3010, 0, 0, 16'h0000, 0, 0, 0, 0, 32'h3014, 1, 0);
      add(0, 1, 1, 3'd3, 32'h3010, 0, 0, 16'h0008, 0, 0, 0, 0, 32'h3018, 0, 0);
      add(0, 1, 1, 3'd3, 32'h3010, 1, 0, 16'h0000, 0, 0, 0, 0, 32'h3014, 1, 0);
      add(0, 1, 0, 3'd0, 32'h3010, 5, 5, 16'hFFFC, 0, 0, 0, 0, 32'h3018, 0, 0);
      while (stq.size() > 0) begin
         s = stq.pop_front();
         apply(s);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {e.pc, e.fv, e.rd, e.ms}) begin
            bad++;
            $display("FAIL branch step %0d: got pc=%h fv=%b rd=%b ms=%b want pc=%h fv=%b rd=%b ms=%b",
                     n, pc_o, fetch_valid_o, redirect_o, misalign_o, e.pc, e.fv, e.rd, e.ms);
         end
         n++;
      end
   endtask

   task automatic test_stall_hold;
      stim_t s;
      exp_t  e;
      int    n = 0;
      add(1, 1, 1, 3'd6, 32'h3020, 0, 0, 0, 26'h0000C10, 0, 0, 0, 32'h3018, 1, 0);
      add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3018, 0, 0);
      add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3018, 0, 0);
      idle(32'h3040);
      idle(32'h3044);
      add(0, 0, 1, 3'd6, 32'h3020, 0, 0, 0, 26'h0000100, 0, 0, 0, 32'h3044, 1, 0);
      add(0, 0, 1, 3'd6, 32'h3020, 0, 0, 0, 26'h0000200, 0, 0, 0, 32'h3044, 1, 0);
      idle(32'h0800);
      idle(32'h0804);
      add(1, 1, 1, 3'd6, 32'h3020, 0, 0, 0, 26'h0000C10, 0, 0, 0, 32'h0804, 1, 0);
      add(0, 1, 1, 3'd0, 32'h3010, 5, 5, 16'hFFFC, 0, 0, 0, 0, 32'h3040, 0, 0);
      add(0, 1, 1, 3'd0, 32'h3010, 5, 5, 16'hFFFC, 0, 0, 0, 0, 32'h3004, 1, 0);
      idle(32'h3008);
      while (stq.size() > 0) begin
         s = stq.pop_front();
         apply(s);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {e.pc, e.fv, e.rd, e.ms}) begin
            bad++;
            $display("FAIL stall_hold step %0d: got pc=%h fv=%b rd=%b ms=%b want pc=%h fv=%b rd=%b ms=%b",
                     n, pc_o, fetch_valid_o, redirect_o, misalign_o, e.pc, e.fv, e.rd, e.ms);
         end
         n++;
      end
   endtask

   task automatic test_jr_wrap;
      stim_t s;
      exp_t  e;
      int    n = 0;
      add(0, 1, 1, 3'd7, 0, 32'h0000_3047, 0, 0, 0, 0, 0, 0, 32'h3044, 1, 1);
      idle(32'h3048);
      add(0, 1, 1, 3'd7, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
      idle(32'h0000_0000);
      idle(32'h0000_0004);
      add(0, 1, 1, 3'd6, 32'hF000_0010, 0, 0, 0, 26'h0000001, 0, 0, 0, 32'hF000_0004, 1, 0);
      add(0, 1, 1, 3'd0, 32'hFFFF_FFF8, 7, 7, 16'h0001, 0, 0, 0, 0, 32'h0000_0000, 1, 0);
      idle(32'h0000_0004);
      while (stq.size() > 0) begin
         s = stq.pop_front();
         apply(s);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {e.pc, e.fv, e.rd, e.ms}) begin
            bad++;
            $display("FAIL jr_wrap step %0d: got pc=%h fv=%b rd=%b ms=%b want pc=%h fv=%b rd=%b ms=%b",
                     n, pc_o, fetch_valid_o, redirect_o, misalign_o, e.pc, e.fv, e.rd, e.ms);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid;
      stim_t s;
      exp_t  e;
      int    n = 0;
      s = '{default: '0};
      s.stall = 1'b1; s.ready = 1'b1; s.bv = 1'b1; s.op = 3'd6;
      s.bpc = 32'h3020; s.idx = 26'h0000C10;
      apply(s);
      @(posedge clk);
      #1;
      s = '{default: '0};
      s.ready = 1'b1;
      apply(s);
      #1;
      reset = 1'b1;
      #2;
      total++;
      if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {32'h0000_3000, 3'b000}) begin
         bad++;
         $display("FAIL async_reset: got pc=%h fv=%b rd=%b ms=%b want pc=00003000 fv=0 rd=0 ms=0",
                  pc_o, fetch_valid_o, redirect_o, misalign_o);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(32'h3000);
      idle(32'h3004);
      idle(32'h3008);
      while (stq.size() > 0) begin
         s = stq.pop_front();
         apply(s);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {e.pc, e.fv, e.rd, e.ms}) begin
            bad++;
            $display("FAIL reset_mid step %0d: got pc=%h fv=%b rd=%b ms=%b want pc=%h fv=%b rd=%b ms=%b",
                     n, pc_o, fetch_valid_o, redirect_o, misalign_o, e.pc, e.fv, e.rd, e.ms);
         end
         n++;
      end
   endtask

`ifdef PC_GEN_EXC_EN
   task automatic test_exc;
      stim_t s;
      exp_t  e;
      int    n = 0;
      add(1, 1, 1, 3'd6, 32'h3020, 0, 0, 0, 26'h0000C10, 0, 0, 0, 32'h3008, 1, 0);
      add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4180, 0, 0);
      idle(32'h4184);
      add(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h3100, 0, 1, 32'h3100, 0, 0);
      idle(32'h3104);
      add(1, 1, 1, 3'd6, 32'h3020, 0, 0, 0, 26'h0000C10, 32'h3200, 1, 1, 32'h4180, 0, 0);
      idle(32'h4184);
      while (stq.size() > 0) begin
         s = stq.pop_front();
         apply(s);
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         total++;
         if ({pc_o, fetch_valid_o, redirect_o, misalign_o} !== {e.pc, e.fv, e.rd, e.ms}) begin
            bad++;
            $display("FAIL exc step %0d: got pc=%h fv=%b rd=%b ms=%b want pc=%h fv=%b rd=%b ms=%b",
                     n, pc_o, fetch_valid_o, redirect_o, misalign_o, e.pc, e.fv, e.rd, e.ms);
         end
         n++;
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      test_reset;
      test_branches;
      test_stall_hold;
      test_jr_wrap;
      test_reset_mid;
`ifdef PC_GEN_EXC_EN
      test_exc;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
